// File: rtl/stream_fifo_pkg.sv
// Shared types and elaboration helpers for the stream FIFO.
// fifo_mode_e selects between refusing writes when full and dropping the oldest entry.
package stream_fifo_pkg;

    typedef enum logic {
        FIFO_BACKPRESSURE = 1'b0,
        FIFO_OVERWRITE    = 1'b1
    } fifo_mode_e;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage for stream_fifo: DEPTH x DATA_WIDTH registers, one sync write, one async read.
// Storage is deliberately not reset; validity is tracked by the pointer/count logic.
module stream_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Single-clock FWFT FIFO with valid/ready on both sides, fill level and almost flags.
// Full behaviour is MODE-selected: refuse writes, or drop the oldest entry and flag overflow.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         AFULL_TH   = DEPTH - 2,
    parameter int         AEMPTY_TH  = 2,
    parameter fifo_mode_e MODE       = FIFO_BACKPRESSURE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CW         = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [CW-1:0]         CNT_ONE   = 1;
    localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_AFULL = CW'(AFULL_TH);
    localparam logic [CW-1:0]         CNT_AEMPT = CW'(AEMPTY_TH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and >= 2");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("stream_fifo: AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("stream_fifo: AEMPTY_TH must be below DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_write;
    logic w_read;
    logic w_drop;
    logic w_mem_we;

    assign w_full    = (r_count == CNT_FULL);
    assign in_ready  = (MODE == FIFO_OVERWRITE) ? 1'b1 : !w_full;
    assign out_valid = (r_count != '0);
    assign w_write   = in_valid & in_ready;
    assign w_read    = out_valid & out_ready;
    // Overwrite with no concurrent pop: the write slot is the oldest entry, so retire it.
    assign w_drop    = (MODE == FIFO_OVERWRITE) & w_full & w_write & !w_read;
    assign w_mem_we  = w_write & !rst & !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_read || w_drop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_write && !w_read && !w_drop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_read && !w_write) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (out_data)
    );

    assign count        = r_count;
    assign almost_full  = (r_count >= CNT_AFULL);
    assign almost_empty = (r_count <= CNT_AEMPT);
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: a backpressure and an overwrite instance share one stimulus stream
// and are each compared every cycle against a queue model, plus directed spot checks.
module tb_stream_fifo;

    localparam int DW = 8;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          bp_ir, bp_ov, bp_af, bp_ae, bp_of;
    logic [DW-1:0] bp_od;
    logic [4:0]    bp_cnt;
    logic          ow_ir, ow_ov, ow_af, ow_ae, ow_of;
    logic [DW-1:0] ow_od;
    logic [4:0]    ow_cnt;

    always #5 clk = ~clk;

    stream_fifo #(
        .DATA_WIDTH (DW), .DEPTH (D), .MODE (stream_fifo_pkg::FIFO_BACKPRESSURE)
    ) u_bp (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (bp_ir), .in_data (in_data),
        .out_valid (bp_ov), .out_ready (out_ready), .out_data (bp_od),
        .count (bp_cnt), .almost_full (bp_af), .almost_empty (bp_ae), .overflow (bp_of)
    );

    stream_fifo #(
        .DATA_WIDTH (DW), .DEPTH (D), .MODE (stream_fifo_pkg::FIFO_OVERWRITE)
    ) u_ow (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (ow_ir), .in_data (in_data),
        .out_valid (ow_ov), .out_ready (out_ready), .out_data (ow_od),
        .count (ow_cnt), .almost_full (ow_af), .almost_empty (ow_ae), .overflow (ow_of)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] qb[$];
    logic [DW-1:0] qo[$];
    bit            ovf_o = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string t, input int qs, input logic [DW-1:0] head,
                             input bit is_ow, input bit ovf_m,
                             input logic [4:0] cnt, input logic ov, input logic ir,
                             input logic [DW-1:0] od, input logic af, input logic ae,
                             input logic of);
        chk({t, "_count"}, 32'(cnt), 32'(qs));
        chk({t, "_out_valid"}, 32'(ov), 32'(qs != 0));
        chk({t, "_in_ready"}, 32'(ir), 32'(is_ow || qs != D));
        chk({t, "_almost_full"}, 32'(af), 32'(qs >= D - 2));
        chk({t, "_almost_empty"}, 32'(ae), 32'(qs <= 2));
        chk({t, "_overflow"}, 32'(of), 32'(ovf_m));
        if (qs != 0) chk({t, "_out_data"}, 32'(od), 32'(head));
    endtask

    // Compare both DUTs with the model mid-cycle, then advance the model across the edge.
    task automatic tick();
        bit rb, wb, ro;
        @(negedge clk);
        check_one("bp", qb.size(), (qb.size() != 0) ? qb[0] : '0, 1'b0, 1'b0,
                  bp_cnt, bp_ov, bp_ir, bp_od, bp_af, bp_ae, bp_of);
        check_one("ow", qo.size(), (qo.size() != 0) ? qo[0] : '0, 1'b1, ovf_o,
                  ow_cnt, ow_ov, ow_ir, ow_od, ow_af, ow_ae, ow_of);
        if (rst || flush) begin
            qb.delete();
            qo.delete();
            ovf_o = 1'b0;
        end else begin
            rb = out_ready && (qb.size() != 0);
            wb = in_valid && (qb.size() < D);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(in_data);
            ro = out_ready && (qo.size() != 0);
            if (ro) void'(qo.pop_front());
            if (in_valid) qo.push_back(in_data);
            if (qo.size() > D) begin
                void'(qo.pop_front());
                ovf_o = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int n, input int base);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = DW'(base + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int written;
        int cycles;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        tick();
        chk("reset_count", 32'(bp_cnt), 0);
        chk("reset_out_valid", 32'(bp_ov), 0);
        chk("reset_in_ready", 32'(bp_ir), 1);
        chk("reset_almost_empty", 32'(bp_ae), 1);
        chk("reset_almost_full", 32'(bp_af), 0);
        rst = 1'b0;

        // Fill to full, try a 17th write, then drain in order.
        write_n(16, 0);
        chk("t1_full_count", 32'(bp_cnt), 16);
        chk("t1_full_in_ready", 32'(bp_ir), 0);
        chk("t1_full_almost_full", 32'(bp_af), 1);
        write_n(1, 16);
        chk("t1_17th_refused", 32'(bp_cnt), 16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t1_drain_data", 32'(bp_od), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("t1_empty", 32'(bp_ov), 0);
        do_flush();

        // Full with simultaneous write and read: backpressure pops only.
        write_n(16, 0);
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h40;
        chk("t2_pop_head", 32'(bp_od), 0);
        tick();
        chk("t2_count_after_pop", 32'(bp_cnt), 15);
        out_ready = 1'b0; in_data = 8'h41;
        tick();
        in_valid = 1'b0;
        chk("t2_count_refill", 32'(bp_cnt), 16);
        do_flush();

        // Overwrite: 20 writes into 16 slots keeps the newest 16.
        write_n(20, 0);
        chk("t3_ow_count", 32'(ow_cnt), 16);
        chk("t3_ow_overflow", 32'(ow_of), 1);
        chk("t3_bp_no_overflow", 32'(bp_of), 0);
        out_ready = 1'b1;
        for (int i = 4; i < 20; i++) begin
            chk("t3_ow_drain", 32'(ow_od), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        do_flush();
        chk("t3_flush_clears_overflow", 32'(ow_of), 0);

        // Random traffic with wrap-around until 100 words are accepted by the backpressure FIFO.
        written = 0;
        cycles  = 0;
        while (written < 100 && cycles < 4000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            in_data   = DW'($urandom);
            if (in_valid && qb.size() < D) written++;
            tick();
            cycles++;
        end
        chk("t4_words_accepted", 32'(written), 100);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) tick();
        out_ready = 1'b0;
        chk("t4_drained", 32'(bp_cnt), 0);
        do_flush();

        // Flush with live handshakes on both sides.
        write_n(5, 8'h20);
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h99; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count", 32'(bp_cnt), 0);
        chk("t5_out_valid", 32'(bp_ov), 0);
        chk("t5_overflow", 32'(ow_of), 0);
        write_n(1, 8'h5A);
        chk("t5_next_word", 32'(bp_od), 32'h5A);
        do_flush();

        // Reset mid-stream, then resume.
        write_n(9, 8'h30);
        chk("t6_pre_count", 32'(bp_cnt), 9);
        in_valid = 1'b1; in_data = 8'h77; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_count", 32'(bp_cnt), 0);
        chk("t6_out_valid", 32'(bp_ov), 0);
        chk("t6_in_ready", 32'(bp_ir), 1);
        write_n(1, 8'hA5);
        chk("t6_out_data", 32'(bp_od), 32'hA5);
        chk("t6_out_valid_after", 32'(bp_ov), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
